// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply/divide unit that sits after the execute stage.
//
// Every operation takes exactly WIDTH cycles from capture to result, whatever the
// operand values, so the pipeline can stall for a fixed time.
//
// Ports:
//   clock           processor clock; all state changes on the rising edge
//   reset           synchronous, active-high; clears all state
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start-multiply pulse (wins over ctrl_DIV)
//   ctrl_DIV        start-divide pulse
//   data_result     registered result, held until the next completion
//   data_exception  overflow / divide-by-zero flag for data_result
//   data_resultRDY  one-cycle pulse while data_result is fresh
//   busy            high while an operation is in flight
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [CNT_W-1:0]     counter_r;
  logic [WIDTH-1:0]     mag_a_r;      // multiplicand, or dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]     mag_b_r;      // divisor magnitude
  logic [2*WIDTH-1:0]   acc_r;        // product accumulator; low half starts as the multiplier
  logic [WIDTH:0]       rem_r;        // partial remainder
  logic                 sign_r;
  logic                 dbz_r;
  logic                 ovf_r;
  logic [WIDTH-1:0]     data_result_r;
  logic                 data_exception_r;

  logic                 busy_s;
  logic                 rdy_s;
  logic                 last_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_acc_next_s;
  logic [2*WIDTH-1:0]   mul_signed_s;
  logic                 mul_exc_s;
  logic [WIDTH+1:0]     div_shift_s;
  logic [WIDTH+1:0]     div_diff_s;
  logic                 div_fit_s;
  logic [WIDTH:0]       div_rem_next_s;
  logic [WIDTH-1:0]     div_quo_next_s;
  logic [WIDTH-1:0]     div_signed_s;
  logic [WIDTH-1:0]     res_next_s;
  logic                 exc_next_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    abs_val = v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign last_s = (counter_r == LAST_CNT);

  // Shift-add step: add the multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
    mul_acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    mul_signed_s   = sign_r ? ({(2*WIDTH){1'b0}} - mul_acc_next_s) : mul_acc_next_s;
    // The product fits in WIDTH signed bits only if its top WIDTH+1 bits agree.
    mul_exc_s      = !((&mul_signed_s[2*WIDTH-1:WIDTH-1]) || ~(|mul_signed_s[2*WIDTH-1:WIDTH-1]));
  end

  // Restoring-division step: shift in the next dividend bit and subtract the
  // divisor only when the trial difference stays non-negative.
  always_comb begin
    div_shift_s    = {rem_r, mag_a_r[WIDTH-1]};
    div_diff_s     = div_shift_s - {2'b00, mag_b_r};
    div_fit_s      = ~div_diff_s[WIDTH+1];
    div_rem_next_s = div_fit_s ? div_diff_s[WIDTH:0] : div_shift_s[WIDTH:0];
    div_quo_next_s = {mag_a_r[WIDTH-2:0], div_fit_s};
    div_signed_s   = sign_r ? ({WIDTH{1'b0}} - div_quo_next_s) : div_quo_next_s;
  end

  // Final result and flag, taken from the last iteration's next values.
  always_comb begin
    res_next_s = data_result_r;
    exc_next_s = data_exception_r;
    case (state_r)
      MUL: begin
        res_next_s = mul_signed_s[WIDTH-1:0];
        exc_next_s = mul_exc_s;
      end
      DIV: begin
        if (dbz_r) begin
          res_next_s = {WIDTH{1'b0}};
          exc_next_s = 1'b1;
        end else if (ovf_r) begin
          res_next_s = MIN_NEG;
          exc_next_s = 1'b1;
        end else begin
          res_next_s = div_signed_s;
          exc_next_s = 1'b0;
        end
      end
      default: begin
        res_next_s = data_result_r;
        exc_next_s = data_exception_r;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; starts are only honoured in IDLE or DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (ctrl_MULT) begin
          state_next_s = MUL;
        end else if (ctrl_DIV) begin
          state_next_s = DIV;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    busy_s = 1'b0;
    rdy_s  = 1'b0;
    case (state_r)
      MUL, DIV: busy_s = 1'b1;
      DONE:     rdy_s  = 1'b1;
      default: begin
        busy_s = 1'b0;
        rdy_s  = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result registration.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter_r        <= {CNT_W{1'b0}};
      mag_a_r          <= {WIDTH{1'b0}};
      mag_b_r          <= {WIDTH{1'b0}};
      acc_r            <= {(2*WIDTH){1'b0}};
      rem_r            <= {(WIDTH+1){1'b0}};
      sign_r           <= 1'b0;
      dbz_r            <= 1'b0;
      ovf_r            <= 1'b0;
      data_result_r    <= {WIDTH{1'b0}};
      data_exception_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            mag_a_r   <= abs_val(data_operandA);
            mag_b_r   <= abs_val(data_operandB);
            acc_r     <= {{WIDTH{1'b0}}, abs_val(data_operandB)};
            rem_r     <= {(WIDTH+1){1'b0}};
            sign_r    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dbz_r     <= !ctrl_MULT && (data_operandB == {WIDTH{1'b0}});
            ovf_r     <= !ctrl_MULT && (data_operandA == MIN_NEG)
                         && (data_operandB == {WIDTH{1'b1}});
            counter_r <= {CNT_W{1'b0}};
          end
        end
        MUL: begin
          acc_r     <= mul_acc_next_s;
          counter_r <= counter_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        DIV: begin
          rem_r     <= div_rem_next_s;
          mag_a_r   <= div_quo_next_s;
          counter_r <= counter_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: counter_r <= counter_r;
      endcase
      if (busy_s && last_s) begin
        data_result_r    <= res_next_s;
        data_exception_r <= exc_next_s;
      end
    end
  end

  assign data_result    = data_result_r;
  assign data_exception = data_exception_r;
  assign data_resultRDY = rdy_s;
  assign busy           = busy_s;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: the driver pushes the expected result, flag
// and completion cycle; the monitor pops and compares on every data_resultRDY.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one start on the next falling edge; optionally push its expectation.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] er, input logic ee, output int cap);
    exp_t e;
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    cap           = cyc;
    if (push) begin
      e.res = er;
      e.exc = ee;
      e.cyc = cap + 33;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = ~a;   // operands must already be latched
    data_operandB = ~b;
  endtask

  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    @(negedge clock);
    while (cyc != t && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (cyc != t) check("wait_cyc_timeout", cyc, t);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic run(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ee);
    int c;
    issue(m, d, a, b, 1'b1, er, ee, c);
    drain();
  endtask

  initial begin
    int c;
    int c2;
    int bad;
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    reset = 1'b0;

    // 1: 7 * -6, busy profile and hold afterwards
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFD6, 1'b0, c);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (busy !== 1'b1) bad++;
    end
    check("busy_during_op", bad, 32'd0);
    @(negedge clock);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    drain();
    repeat (3) @(negedge clock);
    check("hold_result", data_result, 32'hFFFF_FFD6);
    check("hold_rdy_low", {31'd0, data_resultRDY}, 32'd0);

    // 2: multiply overflow and the most negative in-range product
    run(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run(1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);

    // 3: division signs, divide-by-zero and overflow
    run(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    run(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // 4: start ignored mid-op, then back-to-back start in the DONE cycle
    issue(1'b1, 1'b0, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, c);
    wait_cyc(c + 9);
    issue(1'b0, 1'b1, 32'd77, 32'd7, 1'b0, 32'd0, 1'b0, c2);
    wait_cyc(c + 32);
    issue(1'b1, 1'b0, 32'd5, 32'd5, 1'b1, 32'd25, 1'b0, c2);
    check("b2b_capture_cycle", c2, c + 33);
    drain();

    // 5: both starts high -> multiply
    run(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);

    // 6: reset mid-divide, start during reset ignored, then a clean divide
    issue(1'b0, 1'b1, 32'd1000, 32'd10, 1'b0, 32'd0, 1'b0, c);
    wait_cyc(c + 15);
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    data_operandA = 32'd9; data_operandB = 32'd9;
    @(negedge clock);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_result", data_result, 32'd0);
    check("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    @(negedge clock);
    check("rst_start_ignored", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clock);
    run(1'b0, 1'b1, 32'd1000, 32'd10, 32'd100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
